// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared types and constants for the pipeline hazard unit.
//   word_t / regbits_t  : datapath word and register-index types
//   REGSEL_LOAD         : writeback-source code meaning "result comes from memory"
//   hazard_state_t      : hazard FSM states
//   RS_LSB / RT_LSB     : instruction field offsets, with rs_of / rt_of extractors
package hazard_unit_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  localparam logic [1:0] REGSEL_LOAD = 2'b01;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_BUBBLE = 2'b01,
    DWAIT     = 2'b10
  } hazard_state_t;

  function automatic regbits_t rs_of(input word_t instr);
    return instr[RS_LSB +: REG_W];
  endfunction

  function automatic regbits_t rt_of(input word_t instr);
    return instr[RT_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: bundle of all hazard-unit inputs and outputs.
//   modport hu : seen from the hazard unit (pipeline status in, stall/flush/counters out)
//   modport tb : seen from the driver of the pipeline status (the opposite direction)
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  import hazard_unit_pkg::*;

  word_t       instru_de;
  logic        useRt_de;
  logic        isJr_de;
  regbits_t    regDst_ex;
  logic        regWr_ex;
  logic [1:0]  regSel_ex;
  logic        dREN_me;
  logic        dWEN_me;
  logic        dhit;
  logic        ihit;
  logic        redirect_ex;

  logic        stall_fe;
  logic        stall_de;
  logic        stall_ex;
  logic        stall_me;
  logic        flush_de;
  logic        flush_ex;
  logic        flush_me;
  logic        flush_wb;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport hu (
    input  instru_de, useRt_de, isJr_de, regDst_ex, regWr_ex, regSel_ex,
    input  dREN_me, dWEN_me, dhit, ihit, redirect_ex,
    output stall_fe, stall_de, stall_ex, stall_me,
    output flush_de, flush_ex, flush_me, flush_wb,
    output stall_cnt, flush_cnt
  );

  modport tb (
    output instru_de, useRt_de, isJr_de, regDst_ex, regWr_ex, regSel_ex,
    output dREN_me, dWEN_me, dhit, ihit, redirect_ex,
    input  stall_fe, stall_de, stall_ex, stall_me,
    input  flush_de, flush_ex, flush_me, flush_wb,
    input  stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_counter.sv
// hazard_counter: CNT_W-bit event counter that wraps modulo 2^CNT_W.
//   clk_i   : clock
//   rst_i   : synchronous active-high clear
//   en_i    : count this cycle
//   count_o : registered count
module hazard_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: increment when enabled, natural overflow gives the wrap.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush control for the 5-stage pipeline, covering the
// hazards forwarding cannot resolve.
//   CLK  : clock
//   RST  : synchronous active-high reset (all flushes asserted while high)
//   hif  : hazard_unit_if.hu -- pipeline status in; stall_*/flush_* and the
//          stall-cycle / redirect-flush counters out
// Stall/flush outputs are combinational from state and inputs so they act in
// the same cycle; the FSM state and counters are registered.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        CLK,
  input  logic        RST,
  hazard_unit_if.hu   hif
);

  hazard_state_t state_q;
  hazard_state_t state_d;

  regbits_t rs_de_s;
  regbits_t rt_de_s;
  logic     load_ex_s;
  logic     lu_haz_s;
  logic     mem_wait_s;
  logic     lu_mask_s;
  logic     redirect_take_s;
  logic     any_stall_s;

  logic stall_fe_s, stall_de_s, stall_ex_s, stall_me_s;
  logic flush_de_s, flush_ex_s, flush_me_s, flush_wb_s;

  assign rs_de_s = rs_of(hif.instru_de);
  assign rt_de_s = rt_of(hif.instru_de);

  // A jr consumes rs in fetch, so the rs compare already covers isJr_de.
  assign load_ex_s  = hif.regWr_ex && (hif.regSel_ex == REGSEL_LOAD) &&
                      (hif.regDst_ex != 5'd0);
  assign lu_haz_s   = load_ex_s && ((hif.regDst_ex == rs_de_s) ||
                                    (hif.useRt_de && (hif.regDst_ex == rt_de_s)));
  assign mem_wait_s = (hif.dREN_me || hif.dWEN_me) && !hif.dhit;

  // Load-use is masked for the cycle after its bubble: execute holds the bubble.
  always_comb begin
    lu_mask_s = 1'b0;
    case (state_q)
      LU_BUBBLE: lu_mask_s = 1'b1;
      RUN:       lu_mask_s = 1'b0;
      DWAIT:     lu_mask_s = 1'b0;
      default:   lu_mask_s = 1'b0;
    endcase
  end

  // Next state and stall/flush outputs; priority memWait > redirect > luHaz > !ihit.
  always_comb begin
    state_d         = state_q;
    stall_fe_s      = 1'b0;
    stall_de_s      = 1'b0;
    stall_ex_s      = 1'b0;
    stall_me_s      = 1'b0;
    flush_de_s      = 1'b0;
    flush_ex_s      = 1'b0;
    flush_me_s      = 1'b0;
    flush_wb_s      = 1'b0;
    redirect_take_s = 1'b0;
    if (RST) begin
      flush_de_s = 1'b1;
      flush_ex_s = 1'b1;
      flush_me_s = 1'b1;
      flush_wb_s = 1'b1;
      state_d    = RUN;
    end else if (mem_wait_s) begin
      // Freeze the whole pipe; writeback gets a bubble so nothing retires twice.
      stall_fe_s = 1'b1;
      stall_de_s = 1'b1;
      stall_ex_s = 1'b1;
      stall_me_s = 1'b1;
      flush_wb_s = 1'b1;
      state_d    = DWAIT;
    end else begin
      state_d = RUN;
      if (hif.redirect_ex) begin
        flush_de_s      = 1'b1;
        flush_ex_s      = 1'b1;
        redirect_take_s = 1'b1;
      end else if (lu_haz_s && !lu_mask_s) begin
        stall_fe_s = 1'b1;
        stall_de_s = 1'b1;
        flush_ex_s = 1'b1;
        state_d    = LU_BUBBLE;
      end else if (!hif.ihit) begin
        stall_fe_s = 1'b1;
        flush_de_s = 1'b1;
      end else begin
        state_d = RUN;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign any_stall_s = stall_fe_s || stall_de_s || stall_ex_s || stall_me_s;

  hazard_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (any_stall_s),
    .count_o (hif.stall_cnt)
  );

  hazard_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (redirect_take_s),
    .count_o (hif.flush_cnt)
  );

  assign hif.stall_fe = stall_fe_s;
  assign hif.stall_de = stall_de_s;
  assign hif.stall_ex = stall_ex_s;
  assign hif.stall_me = stall_me_s;
  assign hif.flush_de = flush_de_s;
  assign hif.flush_ex = flush_ex_s;
  assign hif.flush_me = flush_me_s;
  assign hif.flush_wb = flush_wb_s;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors for hazard_unit. Each cycle's stimulus pushes
// its hand-computed expected outputs into a queue; a monitor pops and compares
// on the falling edge. Counter expectations are the totals from earlier cycles.
module tb_hazard_unit;

  localparam int CNT_W = 32;

  typedef struct {
    string       nm;
    logic [3:0]  st;   // {fe, de, ex, me}
    logic [3:0]  fl;   // {de, ex, me, wb}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic CLK;
  logic RST;
  exp_t exp_q[$];
  int   checks;
  int   errors;

  hazard_unit_if #(.CNT_W(CNT_W)) hif ();

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .hif (hif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One cycle: drive inputs just after the rising edge and queue the expectation.
  task automatic cyc(input string nm, input logic rst,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic use_rt, input logic jr,
                     input logic [4:0] dst, input logic wr, input logic [1:0] sel,
                     input logic dren, input logic dwen, input logic dh,
                     input logic ih, input logic redir,
                     input logic [3:0] st, input logic [3:0] fl,
                     input int sc, input int fc);
    exp_t e;
    @(posedge CLK);
    #1;
    RST             = rst;
    hif.instru_de   = {6'h23, rs, rt, 16'h0000};
    hif.useRt_de    = use_rt;
    hif.isJr_de     = jr;
    hif.regDst_ex   = dst;
    hif.regWr_ex    = wr;
    hif.regSel_ex   = sel;
    hif.dREN_me     = dren;
    hif.dWEN_me     = dwen;
    hif.dhit        = dh;
    hif.ihit        = ih;
    hif.redirect_ex = redir;
    e.nm = nm;
    e.st = st;
    e.fl = fl;
    e.sc = sc;
    e.fc = fc;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so compare one entry per falling edge.
  initial begin
    exp_t e;
    logic [3:0] got_st;
    logic [3:0] got_fl;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got_st = {hif.stall_fe, hif.stall_de, hif.stall_ex, hif.stall_me};
        got_fl = {hif.flush_de, hif.flush_ex, hif.flush_me, hif.flush_wb};
        checks++;
        if (got_st !== e.st || got_fl !== e.fl) begin
          errors++;
          $display("FAIL %s ctrl: got stall=%b flush=%b want stall=%b flush=%b",
                   e.nm, got_st, got_fl, e.st, e.fl);
        end
        checks++;
        if (hif.stall_cnt !== e.sc || hif.flush_cnt !== e.fc) begin
          errors++;
          $display("FAIL %s cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d",
                   e.nm, hif.stall_cnt, hif.flush_cnt, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    RST             = 1'b1;
    hif.instru_de   = 32'h0;
    hif.useRt_de    = 1'b0;
    hif.isJr_de     = 1'b0;
    hif.regDst_ex   = 5'd0;
    hif.regWr_ex    = 1'b0;
    hif.regSel_ex   = 2'b00;
    hif.dREN_me     = 1'b0;
    hif.dWEN_me     = 1'b0;
    hif.dhit        = 1'b1;
    hif.ihit        = 1'b1;
    hif.redirect_ex = 1'b0;

    //   name             rst rs    rt    use  jr   dst   wr   sel    drn  dwn  dh   ih   rdr  stall    flush    sc  fc
    cyc("rst0",          1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, 0, 0);
    cyc("rst1",          1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, 0, 0);
    cyc("idle",          1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 0, 0);
    cyc("lu_stall",      1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0100, 0, 0);
    cyc("lu_masked",     1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1, 0);
    cyc("lu_again",      1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0100, 1, 0);
    cyc("idle2",         1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 2, 0);
    cyc("reg0_load",     1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 2, 0);
    cyc("rt_unused",     1'b0, 5'd1, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 2, 0);
    cyc("rt_used",       1'b0, 5'd1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0100, 2, 0);
    cyc("idle3",         1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 3, 0);
    cyc("not_load",      1'b0, 5'd2, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 3, 0);
    cyc("dwait1",        1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 3, 0);
    cyc("dwait2",        1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 4, 0);
    cyc("dwait3",        1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 5, 0);
    cyc("dhit_release",  1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 6, 0);
    cyc("idle4",         1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 6, 0);
    cyc("redir_lu",      1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1100, 6, 0);
    cyc("post_redir_lu", 1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0100, 6, 1);
    cyc("idle5",         1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 7, 1);
    cyc("ihit_miss",     1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 7, 1);
    cyc("idle6",         1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8, 1);
    cyc("redir_dwait",   1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0001, 8, 1);
    cyc("redir_release", 1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1100, 9, 1);
    cyc("idle7",         1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 9, 2);
    cyc("jr_lu_stall",   1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0100, 9, 2);
    cyc("bubble_ihit",   1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 10, 2);
    cyc("idle8",         1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 11, 2);
    cyc("dwait_r1",      1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 11, 2);
    cyc("dwait_r2",      1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 12, 2);
    cyc("rst_in_dwait",  1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 13, 2);
    cyc("post_rst",      1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 0, 0);
    cyc("post_rst_lu",   1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0100, 0, 0);
    cyc("idle9",         1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1, 0);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() > 0) begin
        @(negedge CLK);
        #1;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
